// File: rtl/spi_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_engine
//  Description : Single-byte SPI master shift engine, mode 0 (CPOL=0, CPHA=0),
//                MSB first. A transfer is requested with begin_transmission
//                while idle. SCLK is derived from clk by a programmable
//                half-period divider. end_transmission pulses for one cycle
//                when the byte is complete.
//
//  Parameters  : CLK_DIV            clk cycles per SCLK half-period (2..4095)
//
//  Ports       : clk                rising-edge clock
//                rst                synchronous, active-low reset
//                send_data[7:0]     byte to send, sampled on accept
//                begin_transmission transfer request (ignored unless idle)
//                slave_select       upstream chip-select, passed to ss
//                miso               serial data from the slave
//                end_transmission   one-cycle done pulse
//                busy               high from accept until the done cycle ends
//                recv_data[7:0]     last byte received
//                sclk, mosi, ss     SPI bus
//
//  Build option: SPI_TX_MISO_CAPTURE_EN -- when defined, miso is shifted in
//                and presented on recv_data after each byte. When undefined
//                the receive path is absent and recv_data reads 8'h00; the
//                transmit timing is the same in both builds.
//
//  Revision    : 1.0  initial release
// ============================================================================
module spi_tx_engine #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] send_data,
    input  logic       begin_transmission,
    input  logic       slave_select,
    input  logic       miso,
    output logic       end_transmission,
    output logic       busy,
    output logic [7:0] recv_data,
    output logic       sclk,
    output logic       mosi,
    output logic       ss
);

    // Divider is wide enough for the largest legal CLK_DIV (4095).
    localparam int                 c_DIV_W    = 12;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]         c_BITS     = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [3:0]         r_bit_cnt;
    // Only the seven bits still to be sent are held; bit 7 goes straight
    // to mosi on accept.
    logic [6:0]         r_tx;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_busy;
    logic               r_end;

    logic w_tick;
    logic w_rise;
    logic w_fall;

    // Divider terminal count toggles sclk; the current sclk level tells us
    // whether this toggle is a rising or a falling edge.
    assign w_tick = (r_state == XFER) && (r_div == c_DIV_LAST);
    assign w_rise = w_tick && !r_sclk;
    assign w_fall = w_tick &&  r_sclk;

    // Chip-select is owned by the upstream sequencer; pass it through
    // untouched so its timing never depends on the engine state.
    assign ss = slave_select;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_end     <= 1'b0;
        end else begin
            r_end <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= 1'b0;
                    if (begin_transmission) begin
                        r_tx      <= send_data[6:0];
                        r_mosi    <= send_data[7];
                        r_div     <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= XFER;
                    end
                end

                XFER: begin
                    if (w_tick) begin
                        r_div <= '0;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end

                    if (w_rise) begin
                        // Slave samples mosi on this edge; we count the bit.
                        r_sclk    <= 1'b1;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_fall) begin
                        r_sclk <= 1'b0;
                        if (r_bit_cnt < c_BITS) begin
                            // Present the next bit half a period before
                            // the next rising edge.
                            r_mosi <= r_tx[6];
                            r_tx   <= {r_tx[5:0], 1'b0};
                        end else begin
                            // Eighth falling edge closes the byte; mosi
                            // keeps the last bit sent.
                            r_state <= DONE;
                            r_end   <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Requests seen here are deliberately dropped; the
                    // next accept can only happen from IDLE.
                    r_sclk  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_sclk  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sclk             = r_sclk;
    assign mosi             = r_mosi;
    assign busy             = r_busy;
    assign end_transmission = r_end;

`ifdef SPI_TX_MISO_CAPTURE_EN
    logic [7:0] r_rx;
    logic [7:0] r_recv;

    // miso is sampled on the same clk edge that raises sclk, matching the
    // slave's mode-0 launch on the preceding falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx   <= '0;
            r_recv <= '0;
        end else begin
            if (w_rise) begin
                r_rx <= {r_rx[6:0], miso};
            end
            if (r_state == DONE) begin
                r_recv <= r_rx;
            end
        end
    end

    assign recv_data = r_recv;
`else
    // Receive path not built: miso is deliberately left unconnected.
    logic w_unused_miso;
    assign w_unused_miso = miso;
    assign recv_data     = 8'h00;
`endif

endmodule
`default_nettype wire
